// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
// Holds the baud-rate and parity encodings, the 16x oversample constant,
// the receiver state type, and helpers that turn a baud selection into a
// clock divider value.
package uart_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam logic [1:0] PAR_NONE   = 2'b00;
  localparam logic [1:0] PAR_ODD    = 2'b01;
  localparam logic [1:0] PAR_EVEN   = 2'b10;
  localparam logic [1:0] PAR_NONE_B = 2'b11;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  function automatic int baud_hz(input logic [1:0] sel);
    case (sel)
      BAUD_2400: return 2400;
      BAUD_4800: return 4800;
      BAUD_9600: return 9600;
      default:   return 19200;
    endcase
  endfunction

  // Clocks per oversample tick; never below 1 so the divider always advances.
  function automatic int tick_div(input int clk_hz, input logic [1:0] sel);
    int d;
    d = clk_hz / (OVERSAMPLE * baud_hz(sel));
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_tick16.sv
// 16x oversample tick generator.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   baud_rate baud selection (uart_pkg encodings)
//   resync    restart the divider (start-bit edge alignment)
//   tick      one-clock pulse every CLK_HZ/(16*baud) clocks
module uart_rx_tick16
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_rate,
  input  logic       resync,
  output logic       tick
);

  localparam int CW = 24;
  localparam logic [CW-1:0] DIV_2400  = CW'(tick_div(CLK_HZ, BAUD_2400));
  localparam logic [CW-1:0] DIV_4800  = CW'(tick_div(CLK_HZ, BAUD_4800));
  localparam logic [CW-1:0] DIV_9600  = CW'(tick_div(CLK_HZ, BAUD_9600));
  localparam logic [CW-1:0] DIV_19200 = CW'(tick_div(CLK_HZ, BAUD_19200));

  logic [CW-1:0] div_val;
  logic [CW-1:0] cnt;
  logic [1:0]    baud_q;
  logic          restart;

  always_comb begin
    case (baud_rate)
      BAUD_2400: div_val = DIV_2400;
      BAUD_4800: div_val = DIV_4800;
      BAUD_9600: div_val = DIV_9600;
      default:   div_val = DIV_19200;
    endcase
  end

  // A baud change is seen one cycle late through baud_q; that cycle restarts
  // the count so the first tick at the new rate is a full period away.
  assign restart = resync || (baud_rate != baud_q);
  assign tick    = !restart && (cnt == div_val - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      baud_q <= baud_rate;
    end else begin
      baud_q <= baud_rate;
      if (restart || tick) cnt <= '0;
      else                 cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, optional odd/even parity, one stop bit,
// 16x oversampling with centre-of-bit sampling.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   rx           asynchronous serial input, idle high
//   baud_rate    00=2400 01=4800 10=9600 11=19200
//   parity_type  00=none 01=odd 10=even 11=none
//   rx_data      received byte (valid while rx_valid)
//   rx_valid     holding register has an unread byte
//   rx_ready     consumer accepts on rx_valid & rx_ready
//   parity_err   parity mismatch on the held frame (sticky to next frame)
//   frame_err    stop bit sampled low on the held frame (sticky to next frame)
//   overrun      an unread byte was overwritten (sticky until rst)
//   active       a frame is being received
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       active
);

  localparam logic [3:0] HALF_BIT = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] FULL_BIT = 4'(OVERSAMPLE - 1);

  logic      rx_p0, rx_p1;
  rx_state_t state, state_next;
  logic [3:0] tcnt, tcnt_next;
  logic [2:0] bidx, bidx_next;
  logic [7:0] shift, shift_next;
  logic       perr, perr_next;
  logic       tick, resync, load;
  logic       parity_en, is_odd;

  assign parity_en = (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
  assign is_odd    = (parity_type == PAR_ODD);
  assign active    = (state != ST_IDLE);

  uart_rx_tick16 #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .baud_rate (baud_rate),
    .resync    (resync),
    .tick      (tick)
  );

  // Stage p0/p1: two-flop synchronizer for the asynchronous line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    bidx_next  = bidx;
    shift_next = shift;
    perr_next  = perr;
    resync     = 1'b0;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_p1) begin
          state_next = ST_START;
          tcnt_next  = '0;
          resync     = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tcnt == HALF_BIT) begin
            tcnt_next  = '0;
            bidx_next  = '0;
            perr_next  = 1'b0;
            // A line already back high at mid start bit was a glitch.
            state_next = rx_p1 ? ST_IDLE : ST_DATA;
          end else begin
            tcnt_next = tcnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tcnt == FULL_BIT) begin
            tcnt_next  = '0;
            shift_next = {rx_p1, shift[7:1]};
            bidx_next  = bidx + 3'd1;
            if (bidx == 3'd7) state_next = parity_en ? ST_PARITY : ST_STOP;
          end else begin
            tcnt_next = tcnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (tcnt == FULL_BIT) begin
            tcnt_next  = '0;
            // Error when the ones count over data+parity disagrees with the mode.
            perr_next  = (^shift) ^ rx_p1 ^ is_odd;
            state_next = ST_STOP;
          end else begin
            tcnt_next = tcnt + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tcnt == FULL_BIT) begin
            tcnt_next  = '0;
            load       = 1'b1;
            state_next = ST_IDLE;
          end else begin
            tcnt_next = tcnt + 4'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      tcnt  <= '0;
      bidx  <= '0;
      perr  <= 1'b0;
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
      bidx  <= bidx_next;
      perr  <= perr_next;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_next;
  end

  // Holding register: a load wins over a same-cycle acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      rx_data    <= shift;
      rx_valid   <= 1'b1;
      parity_err <= perr;
      frame_err  <= !rx_p1;
      if (rx_valid && !rx_ready) overrun <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: serial frames built from the line protocol, expected
// bytes queued at send time and compared when the DUT hands a byte over.
module tb_uart_rx;

  localparam int CLK_HZ = 614_400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] baud_rate = 2'b10;
  logic [1:0] parity_type = 2'b00;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, active;

  uart_rx #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .baud_rate   (baud_rate),
    .parity_type (parity_type),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .active      (active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  logic exp_overrun = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic int baud_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return 2400;
      2'b01:   return 4800;
      2'b10:   return 9600;
      default: return 19200;
    endcase
  endfunction

  function automatic int bit_clks(input logic [1:0] sel);
    return CLK_HZ / baud_of(sel);
  endfunction

  function automatic logic has_parity(input logic [1:0] pt);
    return (pt == 2'b01) || (pt == 2'b10);
  endfunction

  // Parity bit that makes the total ones count even (10) or odd (01).
  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] pt);
    return (pt == 2'b01) ? ~(^d) : (^d);
  endfunction

  // Reference holding register: an unread byte is replaced by the next one.
  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    if (!rx_ready && exp_q.size() > 0) begin
      exp_q.delete(exp_q.size() - 1);
      exp_overrun = 1'b1;
    end
    e.data = d; e.perr = pe; e.ferr = fe;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
    int n;
    bit found;
    n = bit_clks(baud_rate);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
    if (has_parity(parity_type)) drive_bit(parity_bit(d, parity_type) ^ flip, n);
    if (stop) begin
      drive_bit(1'b1, n);
    end else begin
      rx = 1'b0;
      found = 1'b0;
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        if (!active) begin found = 1'b1; break; end
      end
      check("ferr_back_to_idle", 32'(found), 32'd1);
      rx = 1'b1;
      repeat (2 * n) @(negedge clk);
      check("ferr_active_after", 32'(active), 32'd0);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Monitor: every handover is compared against the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_byte: got %0h, required none", rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_data", 32'(rx_data), 32'(e.data));
        check("sb_parity_err", 32'(parity_err), 32'(e.perr));
        check("sb_frame_err", 32'(frame_err), 32'(e.ferr));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int n, fell, exp_fall;
    bit saw;
    logic [7:0] d;
    logic [1:0] pt;
    logic flip;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_active", 32'(active), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Basic frame 0x55 at 9600, no parity, held unread
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    check("b55_valid", 32'(rx_valid), 1);
    check("b55_data", 32'(rx_data), 32'h55);
    check("b55_active", 32'(active), 0);
    check("b55_overrun", 32'(overrun), 32'(exp_overrun));
    rx_ready = 1'b1;
    wait_drain(100);
    @(negedge clk);
    check("b55_valid_cleared", 32'(rx_valid), 0);

    // Even parity good then bad
    parity_type = 2'b10;
    expect_frame(8'hA3, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b0, 1'b1);
    expect_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b1);
    wait_drain(100);
    check("perr_sticky", 32'(parity_err), 1);

    // Stop bit low
    parity_type = 2'b00;
    expect_frame(8'h0F, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b0, 1'b0);
    wait_drain(100);
    check("ferr_sticky", 32'(frame_err), 1);

    // Start-bit glitch of 4 ticks is rejected
    n = bit_clks(baud_rate);
    exp_fall = 3 + 8 * (n / 16);
    saw = 1'b0;
    fell = -1;
    rx = 1'b0;
    for (int k = 0; k < 4 * n; k++) begin
      @(negedge clk);
      if (k == (n / 16) * 4 - 1) rx = 1'b1;
      if (active) saw = 1'b1;
      if (saw && !active) begin fell = k + 1; break; end
    end
    check("glitch_active_seen", 32'(saw), 1);
    check("glitch_active_fall_at_sample",
          32'((fell >= exp_fall - 3) && (fell <= exp_fall + 3)), 1);
    repeat (2 * n) @(negedge clk);
    check("glitch_no_valid", 32'(rx_valid), 0);

    // Back-to-back with consumer stalled: second byte overwrites
    rx_ready = 1'b0;
    expect_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1);
    expect_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1);
    check("ovr_flag", 32'(overrun), 32'(exp_overrun));
    check("ovr_data", 32'(rx_data), 32'(exp_q[0].data));
    rx_ready = 1'b1;
    wait_drain(100);

    // Reset mid-frame during bit 4
    d = 8'h99;
    drive_bit(1'b0, n);
    for (int i = 0; i < 4; i++) drive_bit(d[i], n);
    drive_bit(d[4], n / 2);
    rst = 1'b1;
    rx = 1'b1;
    exp_overrun = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_rx_valid", 32'(rx_valid), 0);
    check("midrst_rx_data", 32'(rx_data), 0);
    check("midrst_overrun", 32'(overrun), 32'(exp_overrun));
    check("midrst_frame_err", 32'(frame_err), 0);
    check("midrst_parity_err", 32'(parity_err), 0);
    check("midrst_active", 32'(active), 0);
    rst = 1'b0;
    repeat (2 * n) @(negedge clk);
    check("postrst_idle", 32'(active), 0);
    expect_frame(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);
    wait_drain(100);

    // Back-to-back with consumer ready: both delivered, no overrun
    expect_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1);
    expect_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1);
    wait_drain(100);
    check("b2b_no_overrun", 32'(overrun), 32'(exp_overrun));

    // Randomized frames across baud rates and parity modes
    for (int i = 0; i < 8; i++) begin
      baud_rate   = 2'($urandom_range(0, 3));
      pt          = 2'($urandom_range(0, 3));
      parity_type = pt;
      d           = 8'($urandom);
      flip        = has_parity(pt) ? 1'($urandom_range(0, 1)) : 1'b0;
      repeat (4 + $urandom_range(0, 40)) @(negedge clk);
      expect_frame(d, flip, 1'b0);
      send_frame(d, flip, 1'b1);
      wait_drain(100);
    end
    check("rand_no_overrun", 32'(overrun), 32'(exp_overrun));

    repeat (20) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-005 baud_rate  input  2  00=2400, 01=4800, 10=9600, 11=19200 baud.
REQ-006 parity_type  input  2  00=none, 01=odd, 10=even, 11=none.
REQ-007 rx_data  output  8  received byte, valid while rx_valid=1.
REQ-008 rx_valid  output  1  holding register contains an unread byte.
REQ-009 rx_ready  input  1  consumer accepts the byte on a cycle where rx_valid&rx_ready.
REQ-010 parity_err  output  1  sticky until the next accepted frame; set on parity mismatch.
REQ-011 frame_err  output  1  sticky until the next accepted frame; set when stop bit samples 0.
REQ-012 overrun  output  1  sticky until rst; set when a frame completes while rx_valid=1 and not accepted that cycle.
REQ-013 active  output  1  high from start-bit detection to end of stop-bit sample.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 A 16x oversample tick SHALL pulse one clk every CLK_HZ/(16*baud) clks (integer division); the divider SHALL restart on baud_rate change and on rst.
REQ-016 FSM states IDLE, START, DATA, PARITY, STOP; reset state IDLE.
REQ-017 IDLE->START on synchronized rx falling to 0; the tick counter SHALL resynchronize to this edge.
REQ-018 START: after 8 ticks sample rx; 0 -> DATA, 1 -> IDLE (glitch rejected, no flags, no output).
REQ-019 DATA: sample every 16 ticks at bit centre, 8 bits LSB first; after bit 7 -> PARITY if parity enabled, else STOP.
REQ-020 PARITY: sample 16 ticks later; even parity requires XOR(data,bit)=0, odd requires 1; mismatch records parity error.
REQ-021 STOP: sample 16 ticks later; then return to IDLE immediately (no wait for line end), so back-to-back frames are received.
REQ-022 On stop sample, rx_data SHALL load the byte, rx_valid SHALL set, and parity_err/frame_err SHALL update, on the following clk edge; the byte is delivered even with errors.
REQ-023 If rx_valid=1 without acceptance at that load, the new byte SHALL overwrite rx_data and overrun SHALL set.
REQ-024 rx_valid SHALL clear the cycle after rx_valid&rx_ready unless a new load occurs in that same cycle, in which case it stays 1 with new data and no overrun.
REQ-025 baud_rate/parity_type changes mid-frame are unsupported; the FSM SHALL still return to IDLE within one frame time.

Reset
REQ-026 While rst=1: FSM IDLE, counters 0, synchronizer flops 1, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, active=0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no output; after release a new frame requires a fresh falling edge.

Structure
REQ-028 A shared package uart_pkg SHALL hold the baud_rate and parity_type encodings, the 16x oversample constant, and the FSM state type; the transmitter SHALL use the same package.
REQ-029 One sub-module uart_rx_tick16 SHALL generate the oversample tick (inputs clk, rst, baud_rate, resync; output tick).

Verification (CLK_HZ=614_400 -> tick dividers 16/8/4/2)
REQ-030 baud 10, no parity, frame 0x55 -> rx_data=0x55, rx_valid=1, errors 0, active low after stop.
REQ-031 Even parity, byte 0xA3 with parity bit 0 -> parity_err=0; same byte with parity bit 1 -> parity_err=1, rx_data=0xA3.
REQ-032 Stop bit driven 0, byte 0x0F -> frame_err=1, rx_data=0x0F, FSM back in IDLE.
REQ-033 rx low pulse of 4 ticks -> no rx_valid, active returns 0 at the START sample point.
REQ-034 Two back-to-back frames 0x11, 0x22 with rx_ready=0 -> rx_data=0x22, overrun=1; with rx_ready=1 held -> both accepted, overrun=0.
REQ-035 rst pulsed during bit 4 of a frame -> all outputs at reset values; next full frame 0xC3 received correctly.
